seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, the number of consecutive identical samples required before a digit is captured.
REQ-002 SHALL have parameter NUM_DIGITS, default 4, the number of digits in the scanned display.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 seg  input  7  active-low segment bus; bit0=a ... bit6=g.
REQ-006 an  input  NUM_DIGITS  active-low digit enable; bit i selects digit i.
REQ-007 out_ready  input  1  consumer accepts word_bcd when high with word_valid.
REQ-008 word_bcd  output  4*NUM_DIGITS  assembled BCD word; digit i in bits [4i+3:4i].
REQ-009 word_valid  output  1  word_bcd holds a complete, unconsumed word.
REQ-010 pattern_err  output  1  one-cycle pulse: a stable, selected pattern is not a legal digit.
REQ-011 err_digit  output  2  index of the digit that raised pattern_err; held until the next error.
REQ-012 overrun  output  1  one-cycle pulse: a complete word was dropped because word_valid was still set.

Function
REQ-013 Legal patterns SHALL be, as seg[6:0]: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. All other patterns are illegal.
REQ-014 seg and an SHALL be registered once before use; the registered sample is the "sample".
REQ-015 A sample SHALL be "selected" only when exactly one bit of an is low; zero or several low bits are not selected.
REQ-016 Per-sample FSM SHALL be WAIT_STABLE -> CAPTURED. In WAIT_STABLE, a 3-bit counter increments while the sample equals the previous sample and is selected. The counter clears on any change or non-selection.
REQ-017 When the counter reaches STABLE_CYCLES-1 with a legal pattern, the block SHALL write the BCD value into slot i, set captured[i], and move to CAPTURED.
REQ-018 With an illegal pattern at the same point, the block SHALL pulse pattern_err, load err_digit=i, leave captured[i] unchanged, and move to CAPTURED.
REQ-019 CAPTURED SHALL return to WAIT_STABLE, with the counter cleared, on any change of sample or loss of selection. A held input therefore captures at most once.
REQ-020 A recapture of an already-captured slot SHALL overwrite its value.
REQ-021 When all captured bits are set and word_valid=0, the next cycle SHALL load word_bcd from the slots, set word_valid, and clear all captured bits.
REQ-022 The same condition with word_valid=1 and out_ready=0 SHALL clear the captured bits, leave word_bcd unchanged, and pulse overrun.
REQ-023 word_valid SHALL clear on the cycle after word_valid&out_ready. If a completion coincides with acceptance, the new word SHALL load and word_valid SHALL stay 1, with no overrun.
REQ-024 word_bcd SHALL be stable while word_valid=1.
REQ-025 Minimum latency from the first changed raw seg/an to captured[i] SHALL be 1 + STABLE_CYCLES cycles.

Reset
REQ-026 On rst_n low, all state SHALL clear immediately: word_bcd=0, word_valid=0, pattern_err=0, err_digit=0, overrun=0, captured=0, counter=0, FSM=WAIT_STABLE, sample registers=all-ones/blank.
REQ-027 Reset asserted mid-word SHALL discard partial captures; capture SHALL restart on the first clock after rst_n rises.

Structure
REQ-028 Package seg_pkg SHALL hold the ten legal segment constants, the blank pattern 7'b1111111, and the FSM state enum.
REQ-029 Pattern-to-BCD lookup SHALL be a combinational sub-module seg7_to_bcd (in: seg[6:0]; out: bcd[3:0], legal). It is the inverse of the team's BCD-to-seven-segment decoder.

Verification
REQ-030 Scan digits 0..3 with patterns for 1,2,3,4, each held 6 cycles, out_ready=1 -> word_valid=1 with word_bcd=16'h4321, then clears one cycle later.
REQ-031 Digit 2 held with seg=0000001 for 6 cycles -> exactly one pattern_err pulse, err_digit=2, captured[2] stays 0.
REQ-032 Pattern held only STABLE_CYCLES-1 cycles before changing -> no capture; an=4'b0011 for 10 cycles -> no capture.
REQ-033 Two full words 9876 then 5555 with out_ready=0 -> word_bcd stays 16'h9876, one overrun pulse; raise out_ready -> word_valid drops.
REQ-034 Completion of a word in the same cycle as out_ready acceptance -> word_valid stays 1, word_bcd takes the new value, no overrun.
REQ-035 rst_n low after digits 0 and 1 are captured, then a full scan of 7,7,7,7 -> word_bcd=16'h7777 with no stale digits.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: legal active-low
// digit patterns (seg[6:0] = g..a), the blank pattern and the per-sample
// capture FSM states.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [0:0] {
    ST_WAIT_STABLE = 1'b0,
    ST_CAPTURED    = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational inverse of the BCD-to-seven-segment decoder: maps an
// active-low segment pattern back to its BCD digit and flags illegal shapes.
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal
);

  // Pattern lookup; anything that is not one of the ten digits is illegal.
  always_comb begin
    bcd   = 4'd0;
    legal = 1'b1;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: begin
        bcd   = 4'd0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Observes a multiplexed active-low seven-segment display (seg/an), waits
// for each digit to be stable, decodes it to BCD and assembles complete
// words that are handed to a consumer with a valid/ready handshake.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] word_bcd,
  output logic                    word_valid,
  output logic                    pattern_err,
  output logic [1:0]              err_digit,
  output logic                    overrun
);

  localparam logic [2:0]            CNT_LAST = 3'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] ONE      = NUM_DIGITS'(1);

  logic [6:0]              seg_smp, seg_prv;
  logic [NUM_DIGITS-1:0]   an_smp, an_prv;
  logic [2:0]              cnt;
  scan_state_e             state;
  logic [4*NUM_DIGITS-1:0] slot_bcd;
  logic [NUM_DIGITS-1:0]   captured;
  logic [NUM_DIGITS-1:0]   captured_nxt;

  logic [NUM_DIGITS-1:0]   sel_low;
  logic                    selected;
  logic                    same;
  logic                    hold;
  logic [2:0]              cnt_inc;
  logic                    reach;
  logic                    capture_ev;
  logic                    all_captured;
  logic [1:0]              dig_idx;
  logic [3:0]              bcd;
  logic                    legal;

  seg7_to_bcd u_lookup (
    .seg   (seg_smp),
    .bcd   (bcd),
    .legal (legal)
  );

  // Exactly one enable low selects a digit; sel_low is then one-hot.
  assign sel_low      = ~an_smp;
  assign selected     = (sel_low != '0) && ((sel_low & (sel_low - ONE)) == '0);
  assign same         = (seg_smp == seg_prv) && (an_smp == an_prv);
  assign hold         = same && selected;
  assign cnt_inc      = cnt + 3'd1;
  assign reach        = (cnt_inc == CNT_LAST);
  assign capture_ev   = (state == ST_WAIT_STABLE) && hold && reach;
  assign all_captured = &captured;
  // A capture landing on the completion cycle belongs to the next word.
  assign captured_nxt = (all_captured ? '0 : captured) |
                        ((capture_ev && legal) ? sel_low : '0);

  // Encode the selected digit position for error reporting.
  always_comb begin
    dig_idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_idx = sel_low[i] ? 2'(i) : dig_idx;
    end
  end

  // Register the raw display bus, and keep the previous sample for the
  // stability comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_smp <= SEG_BLANK;
      an_smp  <= '1;
      seg_prv <= SEG_BLANK;
      an_prv  <= '1;
    end else begin
      seg_smp <= seg;
      an_smp  <= an;
      seg_prv <= seg_smp;
      an_prv  <= an_smp;
    end
  end

  // Stability FSM: count identical selected samples, capture once, then wait
  // for the input to change before arming again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT_STABLE;
      cnt         <= 3'd0;
      pattern_err <= 1'b0;
      err_digit   <= 2'd0;
    end else begin
      pattern_err <= 1'b0;
      case (state)
        ST_WAIT_STABLE: begin
          if (hold) begin
            cnt <= cnt_inc;
            if (reach) begin
              state <= ST_CAPTURED;
              if (!legal) begin
                pattern_err <= 1'b1;
                err_digit   <= dig_idx;
              end
            end
          end else begin
            cnt <= 3'd0;
          end
        end
        ST_CAPTURED: begin
          if (!hold) begin
            state <= ST_WAIT_STABLE;
            cnt   <= 3'd0;
          end
        end
        default: begin
          state <= ST_WAIT_STABLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // Slot storage, word assembly and consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_bcd   <= '0;
      captured   <= '0;
      word_bcd   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      captured <= captured_nxt;
      if (all_captured) begin
        if (!word_valid || out_ready) begin
          word_bcd   <= slot_bcd;
          word_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_valid && out_ready) begin
        word_valid <= 1'b0;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture_ev && legal && sel_low[i]) begin
          slot_bcd[4*i +: 4] <= bcd;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        out_ready;
  logic [15:0] word_bcd;
  logic        word_valid;
  logic        pattern_err;
  logic [1:0]  err_digit;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int ovr_pulses = 0;

  logic [6:0] pat [0:9];

  seg_scan_decoder #(.STABLE_CYCLES(4), .NUM_DIGITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .out_ready   (out_ready),
    .word_bcd    (word_bcd),
    .word_valid  (word_valid),
    .pattern_err (pattern_err),
    .err_digit   (err_digit),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive digit d with pattern p for n clocks, tallying output pulses.
  task automatic hold(input int d, input logic [6:0] p, input int n);
    an  = ~(4'b0001 << d);
    seg = p;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pattern_err) err_pulses++;
      if (overrun) ovr_pulses++;
    end
  endtask

  task automatic idle(input int n);
    an  = 4'hF;
    seg = 7'h7F;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
    pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
    pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
    pat[9] = 7'b0010000;

    rst_n = 1'b0; an = 4'hF; seg = 7'h7F; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bcd", 32'(word_bcd), 32'h0);
    chk("rst_valid", 32'(word_valid), 32'h0);
    chk("rst_err", 32'(pattern_err), 32'h0);
    chk("rst_errdig", 32'(err_digit), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Basic scan 1,2,3,4 with consumer ready.
    out_ready = 1'b1;
    hold(0, pat[1], 6); hold(1, pat[2], 6); hold(2, pat[3], 6); hold(3, pat[4], 6);
    chk("w1_valid", 32'(word_valid), 32'h1);
    chk("w1_bcd", 32'(word_bcd), 32'h4321);
    @(posedge clk); #1;
    chk("w1_drop", 32'(word_valid), 32'h0);
    chk("w1_keep", 32'(word_bcd), 32'h4321);

    // Illegal pattern on digit 2.
    err_pulses = 0;
    hold(2, 7'b0000001, 6);
    chk("err_pulses", 32'(err_pulses), 32'd1);
    chk("err_digit", 32'(err_digit), 32'd2);
    hold(0, pat[0], 6); hold(1, pat[0], 6); hold(3, pat[0], 6);
    chk("err_nocap", 32'(word_valid), 32'h0);
    hold(2, pat[8], 6);
    chk("err_fill_valid", 32'(word_valid), 32'h1);
    chk("err_fill_bcd", 32'(word_bcd), 32'h0800);
    @(posedge clk); #1;
    chk("err_fill_drop", 32'(word_valid), 32'h0);
    chk("err_pulses_end", 32'(err_pulses), 32'd1);

    // Short hold and multiple enables must not capture.
    out_ready = 1'b0;
    hold(0, pat[1], 6); hold(1, pat[2], 6); hold(2, pat[3], 6);
    hold(3, pat[9], 3);
    chk("short_nocap", 32'(word_valid), 32'h0);
    an = 4'b0011; seg = pat[9];
    repeat (10) begin @(posedge clk); #1; end
    chk("multi_nocap", 32'(word_valid), 32'h0);
    idle(2);
    hold(3, pat[9], 6);
    chk("short_fill_valid", 32'(word_valid), 32'h1);
    chk("short_fill_bcd", 32'(word_bcd), 32'h9321);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("short_drop", 32'(word_valid), 32'h0);

    // Overrun: second word dropped while the first is held.
    out_ready = 1'b0; ovr_pulses = 0;
    hold(0, pat[6], 6); hold(1, pat[7], 6); hold(2, pat[8], 6); hold(3, pat[9], 6);
    chk("ovr_w1_valid", 32'(word_valid), 32'h1);
    chk("ovr_w1_bcd", 32'(word_bcd), 32'h9876);
    hold(0, pat[5], 6); hold(1, pat[5], 6); hold(2, pat[5], 6); hold(3, pat[5], 6);
    chk("ovr_pulses", 32'(ovr_pulses), 32'd1);
    chk("ovr_bcd_kept", 32'(word_bcd), 32'h9876);
    chk("ovr_valid_kept", 32'(word_valid), 32'h1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ovr_drop", 32'(word_valid), 32'h0);

    // Completion coinciding with acceptance.
    out_ready = 1'b0; ovr_pulses = 0;
    hold(0, pat[1], 6); hold(1, pat[1], 6); hold(2, pat[1], 6); hold(3, pat[1], 6);
    chk("co_w1_bcd", 32'(word_bcd), 32'h1111);
    hold(0, pat[2], 6); hold(1, pat[2], 6); hold(2, pat[2], 6); hold(3, pat[2], 5);
    chk("co_pre_valid", 32'(word_valid), 32'h1);
    chk("co_pre_bcd", 32'(word_bcd), 32'h1111);
    out_ready = 1'b1;
    hold(3, pat[2], 1);
    chk("co_valid", 32'(word_valid), 32'h1);
    chk("co_bcd", 32'(word_bcd), 32'h2222);
    chk("co_no_ovr", 32'(ovr_pulses), 32'd0);
    @(posedge clk); #1;
    chk("co_drop", 32'(word_valid), 32'h0);

    // Reset mid-word discards partial captures.
    out_ready = 1'b0;
    hold(0, pat[3], 6); hold(1, pat[3], 6); hold(2, pat[3], 6); hold(3, pat[3], 6);
    chk("rw_w1_bcd", 32'(word_bcd), 32'h3333);
    hold(0, pat[3], 6); hold(1, pat[3], 6);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_rst_valid", 32'(word_valid), 32'h0);
    chk("rw_rst_bcd", 32'(word_bcd), 32'h0);
    chk("rw_rst_errdig", 32'(err_digit), 32'h0);
    out_ready = 1'b1; an = 4'hF; seg = 7'h7F;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    hold(2, pat[7], 6); hold(3, pat[7], 6);
    chk("rw_no_stale", 32'(word_valid), 32'h0);
    hold(0, pat[7], 6); hold(1, pat[7], 6);
    chk("rw_valid", 32'(word_valid), 32'h1);
    chk("rw_bcd", 32'(word_bcd), 32'h7777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
